// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush scheduler.
// Arbitrates stall requests, EX-stage jumps and interrupt redirects into
// per-stage freeze/bubble controls plus a PC redirect. All outputs are
// combinational from state and inputs; state updates on posedge clk.
module pipe_hold_ctrl #(
  parameter int AW        = 32,
  parameter int FLUSH_CYC = 2,
  parameter int TO_W      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_jump_i,
  input  logic [AW-1:0] ex_jump_addr_i,
  input  logic          div_busy_i,
  input  logic          mem_wait_i,
  input  logic          irq_req_i,
  input  logic [AW-1:0] irq_addr_i,
  output logic          stall_o,
  output logic [1:0]    flush_o,
  output logic          redirect_o,
  output logic [AW-1:0] redirect_addr_o,
  output logic          irq_ack_o,
  output logic          stall_timeout_o
);

  // Bubble counter only has to hold FLUSH_CYC-1.
  localparam int FCW = $clog2(FLUSH_CYC + 1);
  localparam logic [FCW-1:0]  FLUSH_LOAD = FCW'(FLUSH_CYC - 1);
  localparam logic [TO_W-1:0] WD_MAX     = '1;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic            pending_reg, pending_next;
  logic [AW-1:0]   pend_addr_reg, pend_addr_next;
  logic [FCW-1:0]  flush_cnt_reg, flush_cnt_next;
  logic [TO_W-1:0] wd_cnt_reg, wd_cnt_next;
  logic            timeout_reg, timeout_next;

  logic            stall_req;
  logic            take_redirect;
  logic [AW-1:0]   take_addr;

  assign stall_req       = div_busy_i | mem_wait_i;
  assign stall_timeout_o = timeout_reg;

  // Next-state, counters and output decode; reset forces the bubble pattern.
  always_comb begin
    state_next      = state_reg;
    pending_next    = pending_reg;
    pend_addr_next  = pend_addr_reg;
    flush_cnt_next  = flush_cnt_reg;
    take_redirect   = 1'b0;
    take_addr       = '0;
    stall_o         = 1'b0;
    flush_o         = 2'b00;
    redirect_o      = 1'b0;
    redirect_addr_o = '0;
    irq_ack_o       = 1'b0;

    case (state_reg)
      S_RUN: begin
        if (stall_req) begin
          stall_o    = 1'b1;
          state_next = S_STALL;
          if (ex_jump_i) begin
            pending_next   = 1'b1;
            pend_addr_next = ex_jump_addr_i;
          end
        end else if (ex_jump_i) begin
          take_redirect = 1'b1;
          take_addr     = ex_jump_addr_i;
        end else if (irq_req_i) begin
          take_redirect = 1'b1;
          take_addr     = irq_addr_i;
          irq_ack_o     = 1'b1;
        end
      end

      S_STALL: begin
        if (stall_req) begin
          stall_o = 1'b1;
          // A later jump while frozen supersedes the captured one.
          if (ex_jump_i) begin
            pending_next   = 1'b1;
            pend_addr_next = ex_jump_addr_i;
          end
        end else if (ex_jump_i) begin
          // Live jump outranks the pending one on the release cycle.
          take_redirect = 1'b1;
          take_addr     = ex_jump_addr_i;
          pending_next  = 1'b0;
        end else if (pending_reg) begin
          take_redirect = 1'b1;
          take_addr     = pend_addr_reg;
          pending_next  = 1'b0;
        end else begin
          // Interrupts are deliberately not taken on the release cycle.
          state_next = S_RUN;
        end
      end

      S_FLUSH: begin
        // EX holds a bubble here, so jumps and interrupts are ignored.
        if (stall_req) begin
          stall_o = 1'b1;
        end else begin
          flush_o        = 2'b01;
          flush_cnt_next = flush_cnt_reg - 1'b1;
          if (flush_cnt_reg <= FCW'(1)) begin
            state_next = S_RUN;
          end
        end
      end

      default: begin
        state_next = S_RUN;
      end
    endcase

    if (take_redirect) begin
      redirect_o      = 1'b1;
      redirect_addr_o = take_addr;
      flush_o         = 2'b11;
      flush_cnt_next  = FLUSH_LOAD;
      state_next      = (FLUSH_CYC > 1) ? S_FLUSH : S_RUN;
    end

    if (!rst_n) begin
      stall_o         = 1'b0;
      flush_o         = 2'b11;
      redirect_o      = 1'b0;
      redirect_addr_o = '0;
      irq_ack_o       = 1'b0;
    end
  end

  // Watchdog: counts consecutive frozen cycles, saturating; timeout is sticky.
  always_comb begin
    wd_cnt_next  = '0;
    timeout_next = timeout_reg;
    if (stall_o) begin
      wd_cnt_next = (wd_cnt_reg == WD_MAX) ? wd_cnt_reg : wd_cnt_reg + 1'b1;
      if (wd_cnt_next == WD_MAX) begin
        timeout_next = 1'b1;
      end
    end
  end

  // State, pending jump, counters and timeout flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_RUN;
      pending_reg   <= 1'b0;
      pend_addr_reg <= '0;
      flush_cnt_reg <= '0;
      wd_cnt_reg    <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pending_reg   <= pending_next;
      pend_addr_reg <= pend_addr_next;
      flush_cnt_reg <= flush_cnt_next;
      wd_cnt_reg    <= wd_cnt_next;
      timeout_reg   <= timeout_next;
    end
  end

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Testbench for pipe_hold_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a rule-level reference model.
module tb_pipe_hold_ctrl;

  localparam int AW        = 32;
  localparam int FLUSH_CYC = 2;
  localparam int TO_W      = 4;
  localparam int TO_LIM    = (1 << TO_W) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_jump_i;
  logic [AW-1:0] ex_jump_addr_i;
  logic          div_busy_i;
  logic          mem_wait_i;
  logic          irq_req_i;
  logic [AW-1:0] irq_addr_i;
  logic          stall_o;
  logic [1:0]    flush_o;
  logic          redirect_o;
  logic [AW-1:0] redirect_addr_o;
  logic          irq_ack_o;
  logic          stall_timeout_o;

  int checks = 0;
  int errors = 0;

  pipe_hold_ctrl #(.AW(AW), .FLUSH_CYC(FLUSH_CYC), .TO_W(TO_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_jump_i       (ex_jump_i),
    .ex_jump_addr_i  (ex_jump_addr_i),
    .div_busy_i      (div_busy_i),
    .mem_wait_i      (mem_wait_i),
    .irq_req_i       (irq_req_i),
    .irq_addr_i      (irq_addr_i),
    .stall_o         (stall_o),
    .flush_o         (flush_o),
    .redirect_o      (redirect_o),
    .redirect_addr_o (redirect_addr_o),
    .irq_ack_o       (irq_ack_o),
    .stall_timeout_o (stall_timeout_o)
  );

  always #5 clk = ~clk;

  // Reference model: bubbles still owed, whether a stall began from normal
  // flow, the deferred jump, and the length of the current freeze.
  int            m_bub;
  bit            m_stalled;
  bit            m_pend;
  logic [AW-1:0] m_paddr;
  int            m_slen;
  bit            m_to;

  logic          e_stall, e_redir, e_ack;
  logic [1:0]    e_flush;
  logic [AW-1:0] e_addr;

  task automatic model_reset();
    m_bub = 0; m_stalled = 0; m_pend = 0; m_paddr = '0; m_slen = 0; m_to = 0;
  endtask

  task automatic model_outputs();
    bit sreq;
    sreq = div_busy_i | mem_wait_i;
    e_stall = 0; e_redir = 0; e_ack = 0; e_flush = 2'b00; e_addr = '0;
    if (!rst_n) begin
      e_flush = 2'b11;
    end else if (m_bub > 0) begin
      if (sreq) e_stall = 1; else e_flush = 2'b01;
    end else if (sreq) begin
      e_stall = 1;
    end else if (m_stalled) begin
      if (ex_jump_i)   begin e_redir = 1; e_addr = ex_jump_addr_i; end
      else if (m_pend) begin e_redir = 1; e_addr = m_paddr; end
    end else if (ex_jump_i) begin
      e_redir = 1; e_addr = ex_jump_addr_i;
    end else if (irq_req_i) begin
      e_redir = 1; e_addr = irq_addr_i; e_ack = 1;
    end
    if (e_redir) e_flush = 2'b11;
  endtask

  task automatic model_update();
    bit sreq;
    sreq = div_busy_i | mem_wait_i;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_slen = e_stall ? m_slen + 1 : 0;
    if (m_slen >= TO_LIM) m_to = 1;
    if (m_bub > 0) begin
      if (!sreq) m_bub = m_bub - 1;
    end else if (sreq) begin
      m_stalled = 1;
      if (ex_jump_i) begin m_pend = 1; m_paddr = ex_jump_addr_i; end
    end else begin
      if (e_redir) begin m_bub = FLUSH_CYC - 1; m_pend = 0; end
      m_stalled = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: compare at negedge, then advance the model at posedge.
  task automatic cycle();
    model_outputs();
    @(negedge clk);
    chk("stall",    AW'(stall_o),         AW'(e_stall));
    chk("flush",    AW'(flush_o),         AW'(e_flush));
    chk("redirect", AW'(redirect_o),      AW'(e_redir));
    chk("addr",     redirect_addr_o,      e_addr);
    chk("irq_ack",  AW'(irq_ack_o),       AW'(e_ack));
    chk("timeout",  AW'(stall_timeout_o), AW'(m_to));
    $display("t=%0t rst_n=%0b jmp=%0b div=%0b mem=%0b irq=%0b | stall=%0b flush=%b redir=%0b addr=%h ack=%0b to=%0b",
             $time, rst_n, ex_jump_i, div_busy_i, mem_wait_i, irq_req_i,
             stall_o, flush_o, redirect_o, redirect_addr_o, irq_ack_o, stall_timeout_o);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    ex_jump_i = 0; div_busy_i = 0; mem_wait_i = 0; irq_req_i = 0;
  endtask

  int stall_left;
  int guard;

  initial begin
    rst_n = 0; idle(); ex_jump_addr_i = '0; irq_addr_i = 32'h0000_0040;
    model_reset();
    @(posedge clk); #1;

    // Reset state, then release.
    cycle();
    rst_n = 1;
    cycle();

    // Jump redirect followed by its bubble.
    ex_jump_i = 1; ex_jump_addr_i = 32'h100;
    cycle();
    idle();
    repeat (3) cycle();

    // Divider stall of five cycles.
    div_busy_i = 1;
    repeat (5) cycle();
    idle();
    repeat (2) cycle();
    chk("no_timeout_short", AW'(stall_timeout_o), '0);

    // Bus wait with a jump captured in its first cycle.
    mem_wait_i = 1; ex_jump_i = 1; ex_jump_addr_i = 32'h80;
    cycle();
    ex_jump_i = 0; ex_jump_addr_i = 32'h0;
    repeat (2) cycle();
    mem_wait_i = 0;
    cycle();
    repeat (3) cycle();

    // Interrupt colliding with a jump; interrupt held until acknowledged.
    irq_req_i = 1; irq_addr_i = 32'h0000_0200;
    ex_jump_i = 1; ex_jump_addr_i = 32'h300;
    cycle();
    ex_jump_i = 0;
    guard = 0;
    while (irq_req_i && guard < 8) begin
      model_outputs();
      if (e_ack) irq_req_i = 0;
      irq_req_i = 1;
      cycle();
      if (e_ack) irq_req_i = 0;
      guard++;
    end
    chk("irq_acked_in_time", AW'(irq_req_i), '0);
    idle();
    repeat (3) cycle();

    // Watchdog: busy held exactly 2^TO_W-1 cycles.
    div_busy_i = 1;
    repeat (TO_LIM) cycle();
    div_busy_i = 0;
    cycle();
    chk("timeout_sticky", AW'(stall_timeout_o), 32'h1);
    repeat (2) cycle();

    // Reset in the middle of a stall with a pending jump.
    rst_n = 0;
    cycle();
    rst_n = 1;
    div_busy_i = 1; ex_jump_i = 1; ex_jump_addr_i = 32'h0000_0abc;
    cycle();
    ex_jump_i = 0;
    cycle();
    rst_n = 0;
    cycle();
    rst_n = 1;
    cycle();
    div_busy_i = 0;
    cycle();
    chk("no_redirect_after_reset", AW'(redirect_o), '0);
    repeat (2) cycle();

    // Random traffic.
    stall_left = 0;
    idle();
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if (stall_left == 0 && $urandom_range(0, 5) == 0) stall_left = $urandom_range(1, 18);
      if (stall_left > 0) begin
        if ($urandom_range(0, 1) == 0) begin div_busy_i = 1; mem_wait_i = 0; end
        else begin div_busy_i = 0; mem_wait_i = 1; end
        stall_left--;
      end else begin
        div_busy_i = 0; mem_wait_i = 0;
      end
      ex_jump_i      = ($urandom_range(0, 3) == 0);
      ex_jump_addr_i = $urandom;
      if (!irq_req_i && $urandom_range(0, 7) == 0) begin
        irq_req_i  = 1;
        irq_addr_i = $urandom;
      end
      model_outputs();
      cycle();
      if (e_ack) irq_req_i = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
